mem_arbiter: RTL and testbench

Two-port arbiter that shares the single physical memory between the instruction-fetch port (port A, read-only) and the MEM-stage data port (port B, read/write). It registers the winning request, drives one memory transaction at a time, and returns the response to the winning port only. The data port wins ties because a MEM-stage stall freezes the whole pipeline. A bounded streak counter keeps fetch from starving.

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch port A (read-only) and data port B (read/write)
// share one memory. B wins ties; a bounded B streak keeps A from starving.
//   state   | meaning
//   IDLE    | no command on memory; arbitrate pending requests
//   GRANT_A | fetch command latched and driven; waiting for mem_resp
//   GRANT_B | data command latched and driven; waiting for mem_resp
module mem_arbiter #(
  parameter int MAX_B_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic [15:0] address_a,
  output logic [15:0] rdata_a,
  output logic        resp_a,
  input  logic        read_b,
  input  logic        write_b,
  input  logic [1:0]  wmask_b,
  input  logic [15:0] address_b,
  input  logic [15:0] wdata_b,
  output logic [15:0] rdata_b,
  output logic        resp_b,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_wmask,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int SW = $clog2(MAX_B_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_B_STREAK);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t        state, state_next;
  logic [SW-1:0] streak;
  logic          cmd_read, cmd_write;
  logic [1:0]    cmd_wmask;
  logic [15:0]   cmd_address, cmd_wdata;
  logic          req_b, grant_a, grant_b, done;

  assign req_b = read_b | write_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    done       = 1'b0;
    resp_a     = 1'b0;
    resp_b     = 1'b0;
    rdata_a    = '0;
    rdata_b    = '0;
    case (state)
      IDLE: begin
        // A wins only when B is quiet or B has used up its streak allowance
        if (read_a && (!req_b || streak == STREAK_MAX)) begin
          grant_a    = 1'b1;
          state_next = GRANT_A;
        end else if (req_b) begin
          grant_b    = 1'b1;
          state_next = GRANT_B;
        end
      end
      GRANT_A: begin
        if (mem_resp) begin
          resp_a     = 1'b1;
          rdata_a    = mem_rdata;
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      GRANT_B: begin
        if (mem_resp) begin
          resp_b     = 1'b1;
          rdata_b    = mem_rdata;
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak      <= '0;
      cmd_read    <= 1'b0;
      cmd_write   <= 1'b0;
      cmd_wmask   <= '0;
      cmd_address <= '0;
      cmd_wdata   <= '0;
    end else if (grant_a) begin
      streak      <= '0;
      cmd_read    <= 1'b1;
      cmd_write   <= 1'b0;
      cmd_wmask   <= '0;
      cmd_address <= address_a;
      cmd_wdata   <= '0;
    end else if (grant_b) begin
      if (!read_a)                   streak <= '0;
      else if (streak != STREAK_MAX) streak <= streak + SW'(1);
      // read and write together is illegal; treat it as a write
      cmd_read    <= read_b & ~write_b;
      cmd_write   <= write_b;
      cmd_wmask   <= wmask_b;
      cmd_address <= address_b;
      cmd_wdata   <= wdata_b;
    end else if (done) begin
      cmd_read    <= 1'b0;
      cmd_write   <= 1'b0;
      cmd_wmask   <= '0;
      cmd_address <= '0;
      cmd_wdata   <= '0;
    end
  end

  assign mem_read    = cmd_read;
  assign mem_write   = cmd_write;
  assign mem_wmask   = cmd_wmask;
  assign mem_address = cmd_address;
  assign mem_wdata   = cmd_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory with programmable latency, requester
// tasks per port, and an in-order scoreboard checked on every resp pulse.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_a = 1'b0;
  logic [15:0] address_a = '0;
  logic [15:0] rdata_a;
  logic        resp_a;
  logic        read_b = 1'b0;
  logic        write_b = 1'b0;
  logic [1:0]  wmask_b = '0;
  logic [15:0] address_b = '0;
  logic [15:0] wdata_b = '0;
  logic [15:0] rdata_b;
  logic        resp_b;
  logic        mem_read, mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_resp;

  mem_arbiter #(.MAX_B_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_a(read_a), .address_a(address_a), .rdata_a(rdata_a), .resp_a(resp_a),
    .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
    .wdata_b(wdata_b), .rdata_b(rdata_b), .resp_b(resp_b),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int cmd_cycles = 0;
  int last_resp_cyc = 0;
  int prev_resp_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pat(input logic [7:0] i);
    return {i, ~i};
  endfunction

  // Behavioural memory: responds combinationally once the command has been up
  // for mem_lat cycles after its first cycle.
  int          mem_lat = 0;
  logic        spur = 1'b0;
  int          wait_cnt;
  logic        loaded = 1'b0;
  logic [15:0] mem [256];
  logic        model_resp;

  assign model_resp = (mem_read | mem_write) && (wait_cnt == mem_lat);
  assign mem_resp   = model_resp | spur;
  assign mem_rdata  = (mem_read && model_resp) ? mem[mem_address[7:0]] : 16'h0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 0;
      if (!loaded) begin
        for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
        mem[8'h40] <= 16'h1234;
        loaded <= 1'b1;
      end
    end else if (model_resp) begin
      wait_cnt <= 0;
      if (mem_write) begin
        if (mem_wmask[1]) mem[mem_address[7:0]][15:8] <= mem_wdata[15:8];
        if (mem_wmask[0]) mem[mem_address[7:0]][7:0]  <= mem_wdata[7:0];
      end
    end else if (mem_read | mem_write) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  always @(posedge clk) cyc++;

  typedef struct {
    bit          port;
    logic        rd, wr;
    logic [1:0]  mask;
    logic [15:0] addr, wdata, rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  task automatic push_exp(input bit port, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [1:0] mask, input logic [15:0] rdata);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    e.addr  = addr;
    if (!port) begin
      e.rd = 1'b1; e.wr = 1'b0; e.wdata = 16'h0000; e.mask = 2'b00;
    end else begin
      e.wr = wr; e.rd = rd & ~wr; e.wdata = wdata; e.mask = mask;
    end
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read | mem_write) cmd_cycles++;
      if (resp_a | resp_b) begin
        resp_cnt++;
        prev_resp_cyc = last_resp_cyc;
        last_resp_cyc = cyc;
        check("resp_exclusive", 32'(resp_a & resp_b), 32'd0);
        if (exp_q.size() == 0) begin
          check("spurious_resp", 32'({resp_a, resp_b}), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("resp_port", 32'(resp_b), 32'(cur.port));
          check("rdata_winner", 32'(cur.port ? rdata_b : rdata_a), 32'(cur.rdata));
          check("rdata_other", 32'(cur.port ? rdata_a : rdata_b), 32'd0);
          check("mem_read", 32'(mem_read), 32'(cur.rd));
          check("mem_write", 32'(mem_write), 32'(cur.wr));
          check("mem_address", 32'(mem_address), 32'(cur.addr));
          check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
          check("mem_wmask", 32'(mem_wmask), 32'(cur.mask));
        end
      end
    end
  end

  // Raise a request, wait (bounded) for its resp, then drop it just after the edge.
  task automatic run_port(input bit port, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [1:0] mask, input int exp_wait);
    int n;
    logic got;
    if (!port) begin
      read_a = 1'b1; address_a = addr;
    end else begin
      read_b = rd; write_b = wr; address_b = addr; wdata_b = wdata; wmask_b = mask;
    end
    n = 0;
    @(negedge clk);
    got = port ? resp_b : resp_a;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      got = port ? resp_b : resp_a;
    end
    check(port ? "resp_b_seen" : "resp_a_seen", 32'(got), 32'd1);
    if (exp_wait >= 0) check("req_to_resp_cycles", n, exp_wait);
    @(posedge clk);
    #1;
    if (!port) read_a = 1'b0;
    else begin read_b = 1'b0; write_b = 1'b0; end
  endtask

  typedef struct {
    bit          port;
    logic        rd, wr;
    logic [15:0] addr, wdata;
    logic [1:0]  mask;
    int          lat;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[8];
  int   r0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 2, 16'h1234};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h8001, 16'hAB00, 2'b10, 0, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h8001, 16'h0000, 2'b00, 1, 16'hABFE};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 2'b00, 0, 16'h05FA};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0006, 16'h1234, 2'b11, 1, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0006, 16'h0000, 2'b00, 3, 16'h1234};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 16'h0007, 16'h5566, 2'b01, 0, 16'h0000};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000, 2'b00, 0, 16'h0766};

    // Reset values
    #3;
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    check("rst_resp", 32'({resp_a, resp_b}), 32'd0);
    check("rst_rdata", 32'({rdata_a, rdata_b}), 32'd0);
    check("rst_streak", 32'(dut.streak), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Minimum turnaround: two back-to-back fetches, zero memory latency
    mem_lat = 0;
    push_exp(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 2'b00, 16'h1234);
    push_exp(1'b0, 1'b1, 1'b0, 16'h0041, 16'h0, 2'b00, pat(8'h41));
    run_port(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 2'b00, 1);
    run_port(1'b0, 1'b1, 1'b0, 16'h0041, 16'h0, 2'b00, 1);
    check("turnaround_gap", last_resp_cyc - prev_resp_cyc, 2);

    // Isolated transactions from the vector table
    foreach (vecs[i]) begin
      mem_lat = vecs[i].lat;
      cmd_cycles = 0;
      r0 = resp_cnt;
      push_exp(vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
               vecs[i].mask, vecs[i].rdata);
      run_port(vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
               vecs[i].mask, vecs[i].lat + 1);
      check("cmd_cycles", cmd_cycles, vecs[i].lat + 1);
      check("resp_count", resp_cnt - r0, 1);
      check("queue_drained", exp_q.size(), 0);
    end

    // Tie with streak at zero: B first, then A
    mem_lat = 1;
    check("tie_streak0", 32'(dut.streak), 32'd0);
    r0 = resp_cnt;
    push_exp(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0, 2'b00, 16'h05FA);
    push_exp(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 2'b00, 16'h1234);
    fork
      run_port(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 2'b00, -1);
      run_port(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0, 2'b00, -1);
    join
    check("tie_resp_count", resp_cnt - r0, 2);
    check("tie_queue", exp_q.size(), 0);

    // Starvation bound: B,B,B,B,A,B
    for (int i = 0; i < 4; i++)
      push_exp(1'b1, 1'b1, 1'b0, 16'h0010 + 16'(i), 16'h0, 2'b00, pat(8'h10 + 8'(i)));
    push_exp(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 2'b00, 16'h1234);
    push_exp(1'b1, 1'b1, 1'b0, 16'h0014, 16'h0, 2'b00, pat(8'h14));
    fork
      begin
        for (int i = 0; i < 5; i++)
          run_port(1'b1, 1'b1, 1'b0, 16'h0010 + 16'(i), 16'h0, 2'b00, -1);
      end
      begin
        run_port(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 2'b00, -1);
        check("streak_after_a", 32'(dut.streak), 32'd0);
      end
    join
    check("starve_queue", exp_q.size(), 0);

    // Requester changes its inputs mid-grant; memory sees the latched values
    mem_lat = 3;
    push_exp(1'b1, 1'b0, 1'b1, 16'h1000, 16'h0F0F, 2'b11, 16'h0000);
    fork
      run_port(1'b1, 1'b0, 1'b1, 16'h1000, 16'h0F0F, 2'b11, 4);
      begin
        repeat (2) @(negedge clk);
        address_b = 16'h2000;
        wdata_b   = 16'hFFFF;
        @(negedge clk);
        check("mid_grant_addr", 32'(mem_address), 32'h1000);
        check("mid_grant_wdata", 32'(mem_wdata), 32'h0F0F);
      end
    join

    // mem_resp while IDLE is ignored
    @(posedge clk);
    #1 spur = 1'b1;
    r0 = resp_cnt;
    @(negedge clk);
    check("idle_resp", 32'({resp_a, resp_b}), 32'd0);
    @(posedge clk);
    #1 spur = 1'b0;
    @(negedge clk);
    check("idle_no_cmd", 32'({mem_read, mem_write}), 32'd0);
    check("idle_resp_count", resp_cnt - r0, 0);

    // Reset in the middle of a fetch grant
    mem_lat = 10;
    read_a = 1'b1;
    address_a = 16'h0040;
    repeat (2) @(negedge clk);
    check("pre_rst_cmd", 32'(mem_read), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_read", 32'(mem_read), 32'd0);
    check("async_rst_addr", 32'(mem_address), 32'd0);
    read_a = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    r0 = resp_cnt;
    repeat (4) @(negedge clk);
    check("post_rst_cmd", 32'({mem_read, mem_write}), 32'd0);
    check("post_rst_streak", 32'(dut.streak), 32'd0);
    check("post_rst_no_resp", resp_cnt - r0, 0);
    check("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
